friscv_rd_scheduler: RTL and testbench

- Write-back scheduler in front of the ISA register file's single write port.
- Arbitrates destination-register writes from ALU, memfy and CSR with round-robin priority, using valid/ready handshakes.
- Drives one registered write port.
- Keeps a pending-write scoreboard so the control unit can stall on RAW and WAW hazards.

---
 rtl/friscv_rd_scheduler.sv | 275 +++++++++++++++++++++++++++
 tb/tb_friscv_rd_scheduler.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/friscv_rd_scheduler.sv
// ============================================================================
// friscv_rd_scheduler
// ----------------------------------------------------------------------------
// Write-back scheduler in front of the ISA register file's single write port.
// ALU, memfy and CSR destination-register writes are arbitrated round-robin
// through valid/ready handshakes and forwarded to one registered write port.
// A pending-write scoreboard lets the control unit stall on RAW (rsX_busy)
// and WAW (issue_ready) hazards.
//
// Parameters:
//   RV32E - 1: 16 architectural registers, 0: 32 registers
//   XLEN  - register width in bits (multiple of 8)
//
// Ports:
//   aclk, arst (async, active-high), srst (sync, active-high)
//   issue_valid/issue_ready/issue_addr  - instruction issue that will write rd
//   rs1_addr/rs1_busy, rs2_addr/rs2_busy - hazard queries
//   {alu,memfy,csr}_valid/_ready/_addr/_val - write-back requests
//   {alu,memfy}_strb                    - byte enables (CSR is all-ones)
//   rd_wr/rd_addr/rd_val/rd_strb        - registered register-file write port
//
// Optional build macro:
//   FRISCV_RD_SCHED_STATS_EN - adds stat_wr_cnt (rd_wr pulses) and
//   stat_stall_cnt (cycles with a write-back requester valid but not ready).
// ============================================================================
module friscv_rd_scheduler #(
    parameter int RV32E = 0,
    parameter int XLEN  = 32
) (
    input  logic              aclk,
    input  logic              arst,
    input  logic              srst,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [4:0]        issue_addr,
    input  logic [4:0]        rs1_addr,
    output logic              rs1_busy,
    input  logic [4:0]        rs2_addr,
    output logic              rs2_busy,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [4:0]        alu_addr,
    input  logic [XLEN-1:0]   alu_val,
    input  logic [XLEN/8-1:0] alu_strb,
    input  logic              memfy_valid,
    output logic              memfy_ready,
    input  logic [4:0]        memfy_addr,
    input  logic [XLEN-1:0]   memfy_val,
    input  logic [XLEN/8-1:0] memfy_strb,
    input  logic              csr_valid,
    output logic              csr_ready,
    input  logic [4:0]        csr_addr,
    input  logic [XLEN-1:0]   csr_val,
    output logic              rd_wr,
    output logic [4:0]        rd_addr,
    output logic [XLEN-1:0]   rd_val,
    output logic [XLEN/8-1:0] rd_strb
`ifdef FRISCV_RD_SCHED_STATS_EN
    ,
    output logic [31:0]       stat_wr_cnt,
    output logic [31:0]       stat_stall_cnt
`endif
);

    localparam int REGNUM = (RV32E != 0) ? 16 : 32;
    localparam int NSTRB  = XLEN / 8;

    localparam logic [1:0] REQ_ALU   = 2'd0;
    localparam logic [1:0] REQ_MEMFY = 2'd1;
    localparam logic [1:0] REQ_CSR   = 2'd2;

    // Register 0 and addresses beyond the register count never reach the
    // register file nor the scoreboard.
    function automatic logic addr_legal(input logic [4:0] addr);
        logic ok;
        if (addr == 5'd0) begin
            ok = 1'b0;
        end else if ((RV32E != 0) && addr[4]) begin
            ok = 1'b0;
        end else begin
            ok = 1'b1;
        end
        return ok;
    endfunction

    logic [1:0]        last_grant_r;
    logic [REGNUM-1:1] pending_r;
    logic              rd_wr_r;
    logic [4:0]        rd_addr_r;
    logic [XLEN-1:0]   rd_val_r;
    logic [NSTRB-1:0]  rd_strb_r;

    logic [2:0]        req_s;
    logic [2:0]        grant_s;
    logic [1:0]        grant_idx_s;
    logic              hs_s;
    logic [4:0]        sel_addr_s;
    logic [XLEN-1:0]   sel_val_s;
    logic [NSTRB-1:0]  sel_strb_s;
    logic              wb_legal_s;
    logic              issue_fire_s;
    logic [31:0]       pend_full_s;
    logic [REGNUM-1:1] pending_nxt_s;

    assign req_s = {csr_valid, memfy_valid, alu_valid};

    // Round-robin grant: search starts just after the last granted requester.
    // Depends only on the valids, never on the requesters' data.
    always_comb begin
        grant_s = 3'b000;
        case (last_grant_r)
            REQ_ALU: begin
                if (req_s[1])      grant_s = 3'b010;
                else if (req_s[2]) grant_s = 3'b100;
                else if (req_s[0]) grant_s = 3'b001;
                else               grant_s = 3'b000;
            end
            REQ_MEMFY: begin
                if (req_s[2])      grant_s = 3'b100;
                else if (req_s[0]) grant_s = 3'b001;
                else if (req_s[1]) grant_s = 3'b010;
                else               grant_s = 3'b000;
            end
            default: begin
                if (req_s[0])      grant_s = 3'b001;
                else if (req_s[1]) grant_s = 3'b010;
                else if (req_s[2]) grant_s = 3'b100;
                else               grant_s = 3'b000;
            end
        endcase
    end

    // Granted requester index and its write-back payload.
    always_comb begin
        grant_idx_s = last_grant_r;
        sel_addr_s  = 5'd0;
        sel_val_s   = {XLEN{1'b0}};
        sel_strb_s  = {NSTRB{1'b0}};
        case (grant_s)
            3'b001: begin
                grant_idx_s = REQ_ALU;
                sel_addr_s  = alu_addr;
                sel_val_s   = alu_val;
                sel_strb_s  = alu_strb;
            end
            3'b010: begin
                grant_idx_s = REQ_MEMFY;
                sel_addr_s  = memfy_addr;
                sel_val_s   = memfy_val;
                sel_strb_s  = memfy_strb;
            end
            3'b100: begin
                grant_idx_s = REQ_CSR;
                sel_addr_s  = csr_addr;
                sel_val_s   = csr_val;
                sel_strb_s  = {NSTRB{1'b1}};
            end
            default: begin
                grant_idx_s = last_grant_r;
            end
        endcase
    end

    // A grant is only ever given to a valid requester, so any grant is a handshake.
    assign hs_s       = |grant_s;
    assign wb_legal_s = hs_s & addr_legal(sel_addr_s);

    assign alu_ready   = grant_s[0];
    assign memfy_ready = grant_s[1];
    assign csr_ready   = grant_s[2];

    // Scoreboard widened to 32 entries so 5-bit addresses index it directly;
    // entry 0 and unimplemented entries read as not pending.
    always_comb begin
        pend_full_s             = 32'd0;
        pend_full_s[REGNUM-1:1] = pending_r;
    end

    // Hazard outputs: WAW stall on issue, RAW busy on sources (no forwarding).
    always_comb begin
        if (addr_legal(issue_addr)) begin
            issue_ready = ~pend_full_s[issue_addr];
        end else begin
            issue_ready = 1'b1;
        end
        if (addr_legal(rs1_addr)) begin
            rs1_busy = pend_full_s[rs1_addr];
        end else begin
            rs1_busy = 1'b0;
        end
        if (addr_legal(rs2_addr)) begin
            rs2_busy = pend_full_s[rs2_addr];
        end else begin
            rs2_busy = 1'b0;
        end
    end

    assign issue_fire_s = issue_valid & issue_ready & addr_legal(issue_addr);

    // Next scoreboard: the write-back clears, an accepted issue sets; set wins.
    always_comb begin
        pending_nxt_s = pending_r;
        for (int i = 1; i < REGNUM; i++) begin
            if (issue_fire_s && (issue_addr == 5'(i))) begin
                pending_nxt_s[i] = 1'b1;
            end else if (wb_legal_s && (sel_addr_s == 5'(i))) begin
                pending_nxt_s[i] = 1'b0;
            end else begin
                pending_nxt_s[i] = pending_r[i];
            end
        end
    end

    // Write port, arbitration pointer and scoreboard state.
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            rd_wr_r      <= 1'b0;
            rd_addr_r    <= 5'd0;
            rd_val_r     <= {XLEN{1'b0}};
            rd_strb_r    <= {NSTRB{1'b0}};
            last_grant_r <= REQ_CSR;
            pending_r    <= {(REGNUM-1){1'b0}};
        end else if (srst) begin
            rd_wr_r      <= 1'b0;
            rd_addr_r    <= 5'd0;
            rd_val_r     <= {XLEN{1'b0}};
            rd_strb_r    <= {NSTRB{1'b0}};
            last_grant_r <= REQ_CSR;
            pending_r    <= {(REGNUM-1){1'b0}};
        end else begin
            rd_wr_r <= wb_legal_s;
            // Address/data hold their last value when nothing is written.
            if (wb_legal_s) begin
                rd_addr_r <= sel_addr_s;
                rd_val_r  <= sel_val_s;
                rd_strb_r <= sel_strb_s;
            end
            if (hs_s) begin
                last_grant_r <= grant_idx_s;
            end
            pending_r <= pending_nxt_s;
        end
    end

    assign rd_wr   = rd_wr_r;
    assign rd_addr = rd_addr_r;
    assign rd_val  = rd_val_r;
    assign rd_strb = rd_strb_r;

`ifdef FRISCV_RD_SCHED_STATS_EN
    logic [31:0] stat_wr_cnt_r;
    logic [31:0] stat_stall_cnt_r;
    logic        stall_s;

    assign stall_s = |(req_s & ~grant_s);

    // Free-running statistics counters, wrapping at 2^32.
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            stat_wr_cnt_r    <= 32'd0;
            stat_stall_cnt_r <= 32'd0;
        end else if (srst) begin
            stat_wr_cnt_r    <= 32'd0;
            stat_stall_cnt_r <= 32'd0;
        end else begin
            stat_wr_cnt_r    <= stat_wr_cnt_r + {31'd0, rd_wr_r};
            stat_stall_cnt_r <= stat_stall_cnt_r + {31'd0, stall_s};
        end
    end

    assign stat_wr_cnt    = stat_wr_cnt_r;
    assign stat_stall_cnt = stat_stall_cnt_r;
`endif

endmodule

// File: tb/tb_friscv_rd_scheduler.sv
// ============================================================================
// tb_friscv_rd_scheduler
// Directed test of friscv_rd_scheduler. Expected register-file writes are
// pushed into a scoreboard queue at handshake time; a negedge monitor pops
// and compares whenever rd_wr is high. Combinational grant/hazard outputs
// are checked directly against hand-computed values. A second instance with
// RV32E=1 covers the out-of-range address case.
// ============================================================================
module tb_friscv_rd_scheduler;

    logic        clk = 1'b0;
    logic        arst, srst;
    logic        issue_valid, issue_ready;
    logic [4:0]  issue_addr, rs1_addr, rs2_addr;
    logic        rs1_busy, rs2_busy;
    logic        alu_valid, alu_ready, memfy_valid, memfy_ready, csr_valid, csr_ready;
    logic [4:0]  alu_addr, memfy_addr, csr_addr;
    logic [31:0] alu_val, memfy_val, csr_val;
    logic [3:0]  alu_strb, memfy_strb;
    logic        rd_wr;
    logic [4:0]  rd_addr;
    logic [31:0] rd_val;
    logic [3:0]  rd_strb;

    // RV32E instance signals
    logic        e_issue_ready, e_rs1_busy, e_rs2_busy;
    logic [4:0]  e_issue_addr, e_rs1_addr;
    logic        e_alu_valid, e_alu_ready, e_memfy_valid, e_memfy_ready, e_csr_ready;
    logic [4:0]  e_alu_addr, e_memfy_addr;
    logic        e_rd_wr;
    logic [4:0]  e_rd_addr;
    logic [31:0] e_rd_val;
    logic [3:0]  e_rd_strb;

`ifdef FRISCV_RD_SCHED_STATS_EN
    logic [31:0] stat_wr_cnt, stat_stall_cnt, e_stat_wr_cnt, e_stat_stall_cnt;
`endif

    always #5 clk = ~clk;

    friscv_rd_scheduler #(.RV32E(0), .XLEN(32)) u_dut (
        .aclk(clk), .arst(arst), .srst(srst),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_addr(issue_addr),
        .rs1_addr(rs1_addr), .rs1_busy(rs1_busy), .rs2_addr(rs2_addr), .rs2_busy(rs2_busy),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr),
        .alu_val(alu_val), .alu_strb(alu_strb),
        .memfy_valid(memfy_valid), .memfy_ready(memfy_ready), .memfy_addr(memfy_addr),
        .memfy_val(memfy_val), .memfy_strb(memfy_strb),
        .csr_valid(csr_valid), .csr_ready(csr_ready), .csr_addr(csr_addr), .csr_val(csr_val),
        .rd_wr(rd_wr), .rd_addr(rd_addr), .rd_val(rd_val), .rd_strb(rd_strb)
`ifdef FRISCV_RD_SCHED_STATS_EN
        , .stat_wr_cnt(stat_wr_cnt), .stat_stall_cnt(stat_stall_cnt)
`endif
    );

    friscv_rd_scheduler #(.RV32E(1), .XLEN(32)) u_dut_e (
        .aclk(clk), .arst(arst), .srst(srst),
        .issue_valid(1'b0), .issue_ready(e_issue_ready), .issue_addr(e_issue_addr),
        .rs1_addr(e_rs1_addr), .rs1_busy(e_rs1_busy), .rs2_addr(5'd0), .rs2_busy(e_rs2_busy),
        .alu_valid(e_alu_valid), .alu_ready(e_alu_ready), .alu_addr(e_alu_addr),
        .alu_val(32'hA5A5_A5A5), .alu_strb(4'hF),
        .memfy_valid(e_memfy_valid), .memfy_ready(e_memfy_ready), .memfy_addr(e_memfy_addr),
        .memfy_val(32'h5A5A_5A5A), .memfy_strb(4'hF),
        .csr_valid(1'b0), .csr_ready(e_csr_ready), .csr_addr(5'd0), .csr_val(32'd0),
        .rd_wr(e_rd_wr), .rd_addr(e_rd_addr), .rd_val(e_rd_val), .rd_strb(e_rd_strb)
`ifdef FRISCV_RD_SCHED_STATS_EN
        , .stat_wr_cnt(e_stat_wr_cnt), .stat_stall_cnt(e_stat_stall_cnt)
`endif
    );

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] v;
        logic [3:0]  s;
    } wr_t;

    wr_t sb[$];
    int  total = 0;
    int  bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] v, input logic [3:0] s);
        wr_t e;
        e.a = a;
        e.v = v;
        e.s = s;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every write-port pulse must match the oldest expected write.
    wr_t mon_e;
    always @(negedge clk) begin
        if (!arst && rd_wr === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_wr: got write to %0d, expected no write", rd_addr);
            end else begin
                mon_e = sb.pop_front();
                chk("wr_addr", {27'd0, rd_addr}, {27'd0, mon_e.a});
                chk("wr_val", rd_val, mon_e.v);
                chk("wr_strb", {28'd0, rd_strb}, {28'd0, mon_e.s});
            end
        end
    end

    initial begin
        arst = 1'b1; srst = 1'b0;
        issue_valid = 1'b0; issue_addr = 5'd0; rs1_addr = 5'd0; rs2_addr = 5'd0;
        alu_valid = 1'b0; alu_addr = 5'd0; alu_val = 32'd0; alu_strb = 4'd0;
        memfy_valid = 1'b0; memfy_addr = 5'd0; memfy_val = 32'd0; memfy_strb = 4'd0;
        csr_valid = 1'b0; csr_addr = 5'd0; csr_val = 32'd0;
        e_issue_addr = 5'd0; e_rs1_addr = 5'd0;
        e_alu_valid = 1'b0; e_alu_addr = 5'd0; e_memfy_valid = 1'b0; e_memfy_addr = 5'd0;
        repeat (3) @(posedge clk);
        #1 arst = 1'b0;

        // Reset state
        issue_addr = 5'd7; rs1_addr = 5'd7;
        #1;
        chk("rst_rd_wr", {31'd0, rd_wr}, 32'd0);
        chk("rst_rd_addr", {27'd0, rd_addr}, 32'd0);
        chk("rst_rd_val", rd_val, 32'd0);
        chk("rst_rd_strb", {28'd0, rd_strb}, 32'd0);
        chk("rst_issue_ready", {31'd0, issue_ready}, 32'd1);
        chk("rst_rs1_busy", {31'd0, rs1_busy}, 32'd0);

        // ALU only
        alu_valid = 1'b1; alu_addr = 5'd5; alu_val = 32'hDEAD_BEEF; alu_strb = 4'hF;
        #1;
        chk("alu_only_ready", {29'd0, csr_ready, memfy_ready, alu_ready}, 32'd1);
        push(5'd5, 32'hDEAD_BEEF, 4'hF);
        step();
        alu_valid = 1'b0;
        #1;
        chk("alu_only_wr", {31'd0, rd_wr}, 32'd1);
        chk("alu_only_addr", {27'd0, rd_addr}, 32'd5);

        // Round robin under full contention, restarting from a sync reset
        srst = 1'b1;
        step();
        srst = 1'b0;
        alu_valid = 1'b1;   alu_addr = 5'd1;   alu_val = 32'h1111_1111;   alu_strb = 4'h3;
        memfy_valid = 1'b1; memfy_addr = 5'd2; memfy_val = 32'h2222_2222; memfy_strb = 4'hC;
        csr_valid = 1'b1;   csr_addr = 5'd3;   csr_val = 32'h3333_3333;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("rr_grant", {29'd0, csr_ready, memfy_ready, alu_ready}, 32'd1 << (i % 3));
            if (i > 0) chk("rr_b2b_wr", {31'd0, rd_wr}, 32'd1);
            case (i % 3)
                0: push(5'd1, 32'h1111_1111, 4'h3);
                1: push(5'd2, 32'h2222_2222, 4'hC);
                default: push(5'd3, 32'h3333_3333, 4'hF);
            endcase
            step();
        end
        alu_valid = 1'b0; memfy_valid = 1'b0; csr_valid = 1'b0;

        // RAW/WAW hazard on x7
        issue_valid = 1'b1; issue_addr = 5'd7;
        #1;
        chk("issue7_ready", {31'd0, issue_ready}, 32'd1);
        step();
        issue_valid = 1'b0; rs1_addr = 5'd7;
        #1;
        chk("raw_busy7", {31'd0, rs1_busy}, 32'd1);
        issue_valid = 1'b1;
        #1;
        chk("waw_stall7", {31'd0, issue_ready}, 32'd0);
        issue_valid = 1'b0;
        memfy_valid = 1'b1; memfy_addr = 5'd7; memfy_val = 32'h0000_0077; memfy_strb = 4'h1;
        #1;
        chk("wb7_grant", {29'd0, csr_ready, memfy_ready, alu_ready}, 32'd2);
        push(5'd7, 32'h0000_0077, 4'h1);
        step();
        memfy_valid = 1'b0;
        #1;
        chk("wb7_wr", {31'd0, rd_wr}, 32'd1);
        chk("wb7_busy_clr", {31'd0, rs1_busy}, 32'd0);
        issue_valid = 1'b1;
        #1;
        chk("reissue7_ready", {31'd0, issue_ready}, 32'd1);
        step();
        issue_valid = 1'b0; rs2_addr = 5'd7;
        #1;
        chk("reissue7_busy", {31'd0, rs2_busy}, 32'd1);

        // Same-cycle issue and write-back to x9: set wins
        issue_valid = 1'b1; issue_addr = 5'd9;
        alu_valid = 1'b1; alu_addr = 5'd9; alu_val = 32'h0000_0099; alu_strb = 4'hF;
        #1;
        chk("same9_issue_ready", {31'd0, issue_ready}, 32'd1);
        chk("same9_grant", {29'd0, csr_ready, memfy_ready, alu_ready}, 32'd1);
        push(5'd9, 32'h0000_0099, 4'hF);
        step();
        issue_valid = 1'b0; alu_valid = 1'b0; rs1_addr = 5'd9;
        #1;
        chk("same9_wr", {31'd0, rd_wr}, 32'd1);
        chk("same9_set_wins", {31'd0, rs1_busy}, 32'd1);

        // Address 0 on CSR, out-of-range on the RV32E instance
        csr_valid = 1'b1; csr_addr = 5'd0; csr_val = 32'h0000_1234; rs1_addr = 5'd0;
        e_alu_valid = 1'b1; e_alu_addr = 5'd20;
        #1;
        chk("x0_grant", {29'd0, csr_ready, memfy_ready, alu_ready}, 32'd4);
        chk("e_oor_grant", {29'd0, e_csr_ready, e_memfy_ready, e_alu_ready}, 32'd1);
        step();
        csr_valid = 1'b0; e_alu_valid = 1'b0; e_rs1_addr = 5'd20; e_issue_addr = 5'd20;
        #1;
        chk("x0_no_wr", {31'd0, rd_wr}, 32'd0);
        chk("x0_busy", {31'd0, rs1_busy}, 32'd0);
        chk("e_oor_no_wr", {31'd0, e_rd_wr}, 32'd0);
        chk("e_oor_busy", {31'd0, e_rs1_busy}, 32'd0);
        chk("e_oor_issue_ready", {31'd0, e_issue_ready}, 32'd1);
        // Both ignored grants still advanced the pointer
        alu_valid = 1'b1;   alu_addr = 5'd10;   alu_val = 32'h0000_000A;   alu_strb = 4'hF;
        memfy_valid = 1'b1; memfy_addr = 5'd11; memfy_val = 32'h0000_000B; memfy_strb = 4'hF;
        e_alu_valid = 1'b1; e_alu_addr = 5'd4; e_memfy_valid = 1'b1; e_memfy_addr = 5'd5;
        #1;
        chk("after_x0_grant", {29'd0, csr_ready, memfy_ready, alu_ready}, 32'd1);
        chk("e_after_oor_grant", {29'd0, e_csr_ready, e_memfy_ready, e_alu_ready}, 32'd2);
        push(5'd10, 32'h0000_000A, 4'hF);
        step();
        alu_valid = 1'b0; e_memfy_valid = 1'b0;
        #1;
        chk("next_memfy_grant", {29'd0, csr_ready, memfy_ready, alu_ready}, 32'd2);
        chk("e_wr", {31'd0, e_rd_wr}, 32'd1);
        chk("e_wr_addr", {27'd0, e_rd_addr}, 32'd5);
        push(5'd11, 32'h0000_000B, 4'hF);
        step();
        memfy_valid = 1'b0; e_alu_valid = 1'b0;

        // Async reset mid-burst with x3, x4 pending
        issue_valid = 1'b1; issue_addr = 5'd3;
        step();
        issue_addr = 5'd4;
        step();
        issue_valid = 1'b0; rs1_addr = 5'd3; rs2_addr = 5'd4;
        #1;
        chk("pend3_busy", {31'd0, rs1_busy}, 32'd1);
        chk("pend4_busy", {31'd0, rs2_busy}, 32'd1);
        alu_valid = 1'b1;   alu_addr = 5'd3;   alu_val = 32'h0000_0033; alu_strb = 4'hF;
        memfy_valid = 1'b1; memfy_addr = 5'd4; memfy_val = 32'h0000_0044; memfy_strb = 4'hF;
        #1;
        chk("burst_grant", {29'd0, csr_ready, memfy_ready, alu_ready}, 32'd1);
        step();
        arst = 1'b1;
        sb.delete();
        #1;
        chk("arst_drop_wr", {31'd0, rd_wr}, 32'd0);
        chk("arst_busy3", {31'd0, rs1_busy}, 32'd0);
        chk("arst_busy4", {31'd0, rs2_busy}, 32'd0);
        chk("arst_grant", {29'd0, csr_ready, memfy_ready, alu_ready}, 32'd1);
`ifdef FRISCV_RD_SCHED_STATS_EN
        chk("arst_stat_wr", stat_wr_cnt, 32'd0);
        chk("arst_stat_stall", stat_stall_cnt, 32'd0);
`endif
        step();
        arst = 1'b0;
        #1;
        chk("post_rst_grant", {29'd0, csr_ready, memfy_ready, alu_ready}, 32'd1);
        push(5'd3, 32'h0000_0033, 4'hF);
        step();
        #1;
        chk("post_rst_grant2", {29'd0, csr_ready, memfy_ready, alu_ready}, 32'd2);
        push(5'd4, 32'h0000_0044, 4'hF);
        step();
        alu_valid = 1'b0; memfy_valid = 1'b0;
        repeat (3) step();
        chk("sb_drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
